wb_port_arbiter: RTL



---
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and the multiply/divide unit (MDU). MDU results wait in a small FIFO
// and use idle writeback slots. The pipeline has priority, but a starvation
// counter forces a one-cycle pipeline stall so queued results always drain.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   pipe_wb_valid  pipeline writeback request
//   pipe_wb_rd     pipeline destination register (rd 0 is ignored)
//   pipe_wb_data   pipeline write data
//   pipe_stall     combinational: freeze MEM/WB and earlier stages this cycle
//   mdu_valid      MDU result valid
//   mdu_rd         MDU destination register (rd 0 is accepted and discarded)
//   mdu_data       MDU result
//   mdu_ready      FIFO accepts a push this cycle
//   rf_we/wa/wd    registered register-file write port
//   pending_mask   bit r set when a live FIFO entry targets register r
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] pending_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

  logic [DEPTH-1:0] q_live;
  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [3:0]       starve_cnt;

  logic fifo_nonempty;
  logic head_live;
  logic head_dead;
  logic pipe_req;
  logic grant_head;
  logic grant_pipe;
  logic push;
  logic pop;

  always_comb begin
    fifo_nonempty = (count != '0);
    head_live     = fifo_nonempty && q_live[rd_ptr];
    // An entry killed by a later pipeline write stays in the FIFO until it
    // reaches the head, where it is dropped without using the port.
    head_dead     = fifo_nonempty && !q_live[rd_ptr];
    pipe_req      = pipe_wb_valid && (pipe_wb_rd != 5'd0);
    pipe_stall    = (starve_cnt == LIMIT_C) && head_live;
    grant_head    = pipe_stall || (!pipe_req && head_live);
    grant_pipe    = !pipe_stall && pipe_req;
    // Readiness looks only at current occupancy; a same-cycle pop never
    // frees a slot for a push.
    mdu_ready     = (count < DEPTH_C);
    push          = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    pop           = grant_head || head_dead;
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) pending_mask[q_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_live     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      // WAW kill: the pipeline write supersedes any older queued result for
      // the same register. The push below is written last, so an entry
      // arriving this cycle survives.
      for (int i = 0; i < DEPTH; i++) begin
        if (grant_pipe && q_live[i] && (q_rd[i] == pipe_wb_rd)) q_live[i] <= 1'b0;
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PW'(1);
      end
      if (push) begin
        q_live[wr_ptr] <= 1'b1;
        q_rd[wr_ptr]   <= mdu_rd;
        q_data[wr_ptr] <= mdu_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (head_live && !grant_head)
        starve_cnt <= (starve_cnt == LIMIT_C) ? LIMIT_C : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (grant_head) begin
      rf_we <= 1'b1;
      rf_wa <= q_rd[rd_ptr];
      rf_wd <= q_data[rd_ptr];
    end else if (grant_pipe) begin
      rf_we <= 1'b1;
      rf_wa <= pipe_wb_rd;
      rf_wd <= pipe_wb_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule
